// File: rtl/cart_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module      : cart_upload_reader
//  Description : Streams a contiguous byte range from cartridge SDRAM to the
//                MiST host over the ioctl upload port. A 2-entry prefetch
//                FIFO hides SDRAM latency from the host's ioctl_rd strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module cart_upload_reader #(
    parameter int ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout,
    input  logic              mem_valid,
    output logic              ioctl_upload,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [ADDR_W-1:0] fetch_left_q;
    logic [ADDR_W-1:0] pop_left_q;
    logic              outstanding_q;
    logic [7:0]        slot0_q;       // FIFO head
    logic [7:0]        slot1_q;
    logic [1:0]        count_q;
    logic              busy_q;
    logic              done_q;
    logic              underrun_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              upload_q;
    logic [7:0]        din_q;

    logic [7:0]        slot0_d;
    logic [7:0]        slot1_d;
    logic [1:0]        count_d;
    logic              w_push;
    logic              w_pop;
    logic              w_empty_rd;
    logic              w_outst_after;
    logic              w_issue;
    logic              w_fill_done;

    // FIFO next state, fetch issue decision and fill-complete detection.
    // Issue looks at the post-update FIFO so a pop or a returning read lets
    // the next request go out on the following cycle.
    always_comb begin
        w_push        = mem_valid && outstanding_q;
        w_pop         = (state_q == ST_STREAM) && ioctl_rd && (count_q != 2'd0);
        w_empty_rd    = (state_q == ST_STREAM) && ioctl_rd && (count_q == 2'd0);
        w_outst_after = outstanding_q && !mem_valid;

        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = mem_dout;
                end else begin
                    slot1_d = mem_dout;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = mem_dout;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = mem_dout;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        w_issue = ((state_q == ST_FILL) || (state_q == ST_STREAM)) &&
                  (fetch_left_q != '0) && !w_outst_after && (count_d < 2'd2);

        w_fill_done = (count_d == 2'd2) ||
                      ((fetch_left_q == '0) && !w_outst_after);
    end

    // Control FSM, fetch engine, FIFO storage and all registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fetch_addr_q  <= '0;
            fetch_left_q  <= '0;
            pop_left_q    <= '0;
            outstanding_q <= 1'b0;
            slot0_q       <= 8'h00;
            slot1_q       <= 8'h00;
            count_q       <= 2'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            underrun_q    <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            upload_q      <= 1'b0;
            din_q         <= 8'h00;
        end else begin
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            count_q       <= count_d;
            mem_rd_q      <= w_issue;
            outstanding_q <= w_issue || w_outst_after;

            // The host-visible byte holds its last value while the FIFO is empty.
            if (count_d != 2'd0) begin
                din_q <= slot0_d;
            end
            if (w_issue) begin
                mem_addr_q   <= fetch_addr_q;
                fetch_addr_q <= fetch_addr_q + c_addr_one;
                fetch_left_q <= fetch_left_q - c_addr_one;
            end
            if (w_pop) begin
                pop_left_q <= pop_left_q - c_addr_one;
            end
            if (w_empty_rd) begin
                underrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q     <= 1'b1;
                        underrun_q <= 1'b0;
                        count_q    <= 2'd0;
                        pop_left_q <= length;
                        if (length == '0) begin
                            fetch_addr_q <= base_addr;
                            fetch_left_q <= '0;
                            state_q      <= ST_FINISH;
                        end else begin
                            // First read goes out immediately from base_addr.
                            mem_rd_q      <= 1'b1;
                            mem_addr_q    <= base_addr;
                            fetch_addr_q  <= base_addr + c_addr_one;
                            fetch_left_q  <= length - c_addr_one;
                            outstanding_q <= 1'b1;
                            state_q       <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_fill_done) begin
                        upload_q <= 1'b1;
                        state_q  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_pop && (pop_left_q == c_addr_one)) begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        upload_q <= 1'b0;
                        state_q  <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // Arriving from STREAM done is already high and must drop;
                    // arriving from a zero-length start done has yet to pulse.
                    done_q   <= !done_q;
                    busy_q   <= 1'b0;
                    upload_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign ioctl_upload = upload_q;
    assign ioctl_din    = din_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cart_upload_reader
//  Description : Self-checking bench for cart_upload_reader: a cycle table
//                with hand-driven memory returns, then streamed uploads
//                against a latency-programmable SDRAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_upload_reader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        start;
    logic [24:0] base_addr;
    logic [24:0] length;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_dout;
    logic        mem_valid;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    cart_upload_reader #(.ADDR_W(25)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_dout     (mem_dout),
        .mem_valid    (mem_valid),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_din    (ioctl_din)
    );

    typedef struct {
        logic        st;
        logic [24:0] base;
        logic [24:0] len;
        logic        rd;
        logic        mv;
        logic [7:0]  md;
        logic        e_busy;
        logic        e_done;
        logic        e_up;
        logic        e_mrd;
        logic        e_und;
        logic [24:0] e_addr;
        logic [7:0]  e_din;
    } vec_t;

    vec_t vecs[18];

    // SDRAM responder state
    int          latency = 1;
    logic        pend    = 1'b0;
    int          cnt     = 0;
    logic [24:0] paddr   = '0;
    logic [24:0] log_addr[$];

    function automatic logic [7:0] mem_byte(input logic [24:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo * 8'd7 + 8'd3;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic responder();
        forever begin
            @(posedge clk_sys);
            #1;
            mem_valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    mem_valid = 1'b1;
                    mem_dout  = mem_byte(paddr);
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mem_rd) begin
                pend  = 1'b1;
                paddr = mem_addr;
                cnt   = latency;
                log_addr.push_back(mem_addr);
            end
        end
    endtask

    task automatic run_upload(input string tag, input logic [24:0] base, input logic [24:0] len,
                              input int lat, input int rd_every, input int mid_start,
                              input logic exp_under);
        logic [7:0]  got[$];
        logic [24:0] a;
        int          ndone = 0;
        int          upcnt = 0;
        logic        fin   = 1'b0;
        logic        seen  = 1'b0;
        logic        und_at_rise = 1'b0;
        latency = lat;
        log_addr.delete();
        start = 1'b1; base_addr = base; length = len;
        step();
        start = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            start = (c == mid_start);
            if (c == mid_start) begin
                base_addr = 25'h777;
                length    = 25'd9;
            end
            if (done) begin
                ndone++;
                fin = 1'b1;
            end
            if (ioctl_upload) begin
                if (!seen) begin
                    seen = 1'b1;
                    und_at_rise = underrun;
                    got.push_back(ioctl_din);
                end else if (ioctl_din != got[$]) begin
                    got.push_back(ioctl_din);
                end
                ioctl_rd = ((upcnt % rd_every) == 0);
                upcnt++;
            end else begin
                ioctl_rd = 1'b0;
            end
            step();
        end
        ioctl_rd = 1'b0;
        start    = 1'b0;
        chk($sformatf("%s finished", tag), 32'(fin), 32'd1);
        chk($sformatf("%s busy after done", tag), 32'(busy), 32'd0);
        chk($sformatf("%s upload after done", tag), 32'(ioctl_upload), 32'd0);
        repeat (3) begin
            if (done) ndone++;
            step();
        end
        chk($sformatf("%s done pulses", tag), 32'(ndone), 32'd1);
        chk($sformatf("%s underrun", tag), 32'(underrun), 32'(exp_under));
        chk($sformatf("%s underrun at upload rise", tag), 32'(und_at_rise), 32'd0);
        chk($sformatf("%s mem_rd count", tag), 32'(log_addr.size()), 32'(len));
        for (int i = 0; i < log_addr.size() && i < int'(len); i++) begin
            a = base + 25'(i);
            chk($sformatf("%s mem_addr[%0d]", tag, i), 32'(log_addr[i]), 32'(a));
        end
        chk($sformatf("%s byte count", tag), 32'(got.size()), 32'(len));
        for (int i = 0; i < got.size() && i < int'(len); i++) begin
            a = base + 25'(i);
            chk($sformatf("%s byte[%0d]", tag, i), 32'(got[i]), 32'(mem_byte(a)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //          st    base      len     rd    mv    md      busy  done  up    mrd   und   addr      din
        vecs[0]  = '{1'b1, 25'h10, 25'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 25'h10, 8'h00};
        vecs[1]  = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25'h10, 8'h00};
        vecs[2]  = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[3]  = '{1'b0, 25'h00, 25'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[4]  = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[5]  = '{1'b1, 25'h20, 25'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[6]  = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[7]  = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[8]  = '{1'b0, 25'h00, 25'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[9]  = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h10, 8'hA5};
        vecs[10] = '{1'b1, 25'h40, 25'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 25'h40, 8'hA5};
        vecs[11] = '{1'b0, 25'h00, 25'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25'h40, 8'hA5};
        vecs[12] = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 25'h41, 8'h11};
        vecs[13] = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25'h41, 8'h11};
        vecs[14] = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 25'h41, 8'h11};
        vecs[15] = '{1'b0, 25'h00, 25'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 25'h41, 8'h22};
        vecs[16] = '{1'b0, 25'h00, 25'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 25'h41, 8'h22};
        vecs[17] = '{1'b0, 25'h00, 25'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h41, 8'h22};

        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        ioctl_rd = 1'b0; mem_valid = 1'b0; mem_dout = 8'h00;
        step();
        step();
        reset = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset underrun", 32'(underrun), 32'd0);
        chk("reset mem_rd", 32'(mem_rd), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset upload", 32'(ioctl_upload), 32'd0);
        chk("reset din", 32'(ioctl_din), 32'd0);

        for (int i = 0; i < 18; i++) begin
            start     = vecs[i].st;
            base_addr = vecs[i].base;
            length    = vecs[i].len;
            ioctl_rd  = vecs[i].rd;
            mem_valid = vecs[i].mv;
            mem_dout  = vecs[i].md;
            step();
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d upload", i), 32'(ioctl_upload), 32'(vecs[i].e_up));
            chk($sformatf("vec%0d mem_rd", i), 32'(mem_rd), 32'(vecs[i].e_mrd));
            chk($sformatf("vec%0d underrun", i), 32'(underrun), 32'(vecs[i].e_und));
            chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d din", i), 32'(ioctl_din), 32'(vecs[i].e_din));
        end
        start = 1'b0; ioctl_rd = 1'b0; mem_valid = 1'b0;
        step();

        fork
            responder();
        join_none

        // Slow host, latency 3, with an ignored start mid-upload.
        run_upload("basic", 25'h100, 25'd4, 3, 8, 5, 1'b0);
        // Slow memory, host strobing every cycle: underrun expected.
        run_upload("underrun", 25'h050, 25'd3, 10, 1, -1, 1'b1);
        // Address wrap at the top of the space.
        run_upload("wrap", 25'h1FFFFFF, 25'd2, 2, 1, -1, 1'b0);

        // Reset with a read outstanding, followed by a late mem_valid.
        latency = 5;
        start = 1'b1; base_addr = 25'h200; length = 25'd3;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst-mid busy", 32'(busy), 32'd0);
        chk("rst-mid done", 32'(done), 32'd0);
        chk("rst-mid underrun", 32'(underrun), 32'd0);
        chk("rst-mid mem_rd", 32'(mem_rd), 32'd0);
        chk("rst-mid mem_addr", 32'(mem_addr), 32'd0);
        chk("rst-mid upload", 32'(ioctl_upload), 32'd0);
        chk("rst-mid din", 32'(ioctl_din), 32'd0);
        repeat (8) step();
        chk("late valid din", 32'(ioctl_din), 32'd0);
        chk("late valid upload", 32'(ioctl_upload), 32'd0);
        chk("late valid busy", 32'(busy), 32'd0);
        ioctl_rd = 1'b1;
        step();
        ioctl_rd = 1'b0;
        chk("idle rd underrun", 32'(underrun), 32'd0);
        run_upload("post_reset", 25'h300, 25'd2, 1, 2, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cart_upload_reader.md
# cart_upload_reader

Streams a contiguous byte range out of cartridge SDRAM to the MiST host through the ioctl upload port. It is the read-back counterpart of the download path, which writes ioctl bytes into SDRAM. The block sits beside the SDRAM read mux in the top level and owns the SDRAM read port while `busy` is high. A 2-entry prefetch FIFO hides SDRAM latency from the host's `ioctl_rd` strobes.

## Interface
Parameters:
- `ADDR_W`, 25: SDRAM byte-address width; also the width of `length`.

Ports:
- `clk_sys`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins an upload. Ignored while `busy`.
- `base_addr`  in  ADDR_W  first SDRAM byte address; sampled on `start`.
- `length`  in  ADDR_W  byte count; sampled on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last byte has been popped.
- `underrun`  out  1  sticky; set by an `ioctl_rd` with the FIFO empty. Cleared by `start` or `reset`.
- `mem_addr`  out  ADDR_W  SDRAM read address; valid while `mem_rd` is high.
- `mem_rd`  out  1  one-cycle read request.
- `mem_dout`  in  8  SDRAM read data.
- `mem_valid`  in  1  one-cycle strobe qualifying `mem_dout`; arrives ≥1 cycle after `mem_rd`.
- `ioctl_upload`  out  1  level to mist_io; the host may strobe `ioctl_rd` only while this is high.
- `ioctl_rd`  in  1  one-cycle host strobe; pops the current byte.
- `ioctl_din`  out  8  FIFO head byte to the host.

## Operation
States:
- IDLE: waits for `start`.
  - On `start`: latch `fetch_addr = base_addr`, `fetch_left = length`, `pop_left = length`; clear `underrun` and the FIFO.
  - If `length == 0`: go to FINISH.
  - Otherwise: go to FILL.
- FILL: prefetches. Moves to STREAM once the FIFO holds 2 bytes, or holds all remaining bytes (`fetch_left == 0`). `ioctl_upload` stays low in FILL.
- STREAM:
  - `ioctl_upload` is high; `ioctl_din` is the FIFO head.
  - Each `ioctl_rd` with the FIFO non-empty pops the head and decrements `pop_left`.
  - When `pop_left` goes to 0: go to FINISH.
- FINISH: pulses `done` for one cycle, drops `busy` and `ioctl_upload`, then returns to IDLE.

Fetch engine (active in FILL and STREAM):
- Issues `mem_rd` when `fetch_left != 0`, no read is outstanding, and `fifo_count + outstanding < 2`.
- At most one read is outstanding.
- On issue: `fetch_addr` increments modulo 2^ADDR_W, so wrap-around is silent. `fetch_left` decrements.
- `mem_valid` with a read outstanding pushes `mem_dout` and clears the outstanding flag.
- `mem_valid` with no read outstanding is ignored.

Boundary rules:
- No overflow by construction. Push and pop in the same cycle leaves `fifo_count` unchanged.
- `ioctl_rd` with the FIFO empty (including a `mem_valid` in the same cycle; there is no bypass):
  - sets `underrun`;
  - pops nothing and leaves `pop_left` unchanged;
  - leaves `ioctl_din` holding its last value.
- `ioctl_rd` outside STREAM is ignored and does not set `underrun`.
- `start` while `busy` is ignored, and latched values are unchanged.
- `reset` mid-operation forces IDLE, empties the FIFO and clears the outstanding flag. A `mem_valid` arriving after reset is therefore ignored.

## Timing
- Reset values: `busy` 0, `done` 0, `underrun` 0, `mem_rd` 0, `mem_addr` 0, `ioctl_upload` 0, `ioctl_din` 0.
- `start` in cycle N:
  - `busy` is high in N+1;
  - the first `mem_rd` (address `base_addr`) is in N+1.
- Earliest `ioctl_upload` rise: 1 cycle after the `mem_valid` that completes FILL.
- `ioctl_rd` in cycle M:
  - the next byte appears on `ioctl_din` in M+1 if the FIFO held it;
  - the refill `mem_rd` can issue in M+1.
- `length == 0`: `done` in N+2, `busy` high only in N+1, no `mem_rd`, `ioctl_upload` never rises.
- Final pop in cycle M: `done` and the falls of `ioctl_upload` and `busy` all occur in M+1.
- All outputs are registered.

## Test plan
- `base_addr=0x100`, `length=4`, memory latency 3 cycles, `ioctl_rd` every 8 cycles:
  - `mem_rd` at addresses 0x100..0x103, each exactly once;
  - host sees bytes in order;
  - one `done` pulse; `underrun` stays 0.
- `length=0` -> `done` 2 cycles after `start`; no `mem_rd`; `ioctl_upload` stays 0.
- `base_addr=2^25-1`, `length=2` -> `mem_addr` sequence is 0x1FFFFFF then 0x0000000.
- Memory latency 10, `ioctl_rd` every cycle in STREAM:
  - `underrun` is set on the first empty-FIFO strobe;
  - all 3 bytes are still delivered in order;
  - `done` fires only after the 3rd successful pop.
- `reset` asserted with a read outstanding, then a late `mem_valid` arrives:
  - outputs are at their reset values;
  - the FIFO stays empty;
  - a subsequent `start` works normally.
- Second `start` pulsed mid-upload with a different `base_addr` -> ignored; addresses continue from the original range.
